// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_TAG_W = 5;
  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MULT = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;
endpackage

// File: rtl/multdiv_iter_counter.sv
// Iteration counter: synchronous clear, count enable, terminal flag on the last iteration.
module multdiv_iter_counter
  import multdiv_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  logic [MD_CNT_W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)    r_count <= '0;
    else if (i_clear)  r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == MD_CNT_W'(MD_ITERS - 1));
endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (shift-add) / divide (restoring) on magnitudes, 32 steps,
// returning a one-cycle result_rdy pulse with result, tag and exception.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int TAG_W = MD_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [TAG_W-1:0] dest_tag_in,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_rdy,
  output logic             exception,
  output logic [1:0]       o_dbg_state
);
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          r_state, w_state_nxt;
  logic               w_start, w_cnt_clear, w_cnt_en, w_cnt_tc;
  logic [WIDTH:0]     r_hi, r_b_mag, w_hi_nxt, w_b_mag, w_mul_sum, w_div_sh;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt, w_a_mag, w_q;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic               r_neg, w_div_ok, w_mul_exc, w_div_exc;
  logic [TAG_W-1:0]   r_tag;

  // Start handshake: a request is taken only while idle; multiply has priority.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cnt_clear = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: if (ctrl_mult || ctrl_div) begin
        w_start     = 1'b1;
        w_cnt_clear = 1'b1;
        if (ctrl_mult)            w_state_nxt = ST_MULT;
        else if (operand_b == '0) w_state_nxt = ST_DONE;
        else                      w_state_nxt = ST_DIV;
      end
      ST_MULT, ST_DIV: begin
        w_cnt_en = 1'b1;
        if (w_cnt_tc) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  multdiv_iter_counter u_iter_counter (
    .i_clock   (clock),
    .i_reset_n (reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_en),
    .o_tc      (w_cnt_tc)
  );

  // Magnitudes kept unsigned so that the most negative operand is represented exactly.
  assign w_a_mag = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
  assign w_b_mag = {1'b0, (operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b)};

  assign w_mul_sum  = r_hi + (r_lo[0] ? r_b_mag : '0);
  assign w_div_sh   = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
  assign w_div_diff = {1'b0, w_div_sh} - {1'b0, r_b_mag};
  assign w_div_ok   = !w_div_diff[WIDTH+1];

  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_state == ST_MULT) begin
      w_hi_nxt = {1'b0, w_mul_sum[WIDTH:1]};
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == ST_DIV) begin
      w_hi_nxt = w_div_ok ? w_div_diff[WIDTH:0] : w_div_sh;
      w_lo_nxt = {r_lo[WIDTH-2:0], w_div_ok};
    end
  end

  // Final sign fix-up and overflow detection, evaluated on the last iteration.
  assign w_prod_mag = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
  assign w_prod     = r_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;
  assign w_mul_exc  = !((&w_prod[2*WIDTH-1:WIDTH-1]) || !(|w_prod[2*WIDTH-1:WIDTH-1]));
  assign w_q        = r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
  assign w_div_exc  = r_neg ? (w_lo_nxt > MIN_MAG) : w_lo_nxt[WIDTH-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_b_mag    <= '0;
      r_neg      <= 1'b0;
      r_tag      <= '0;
      result     <= '0;
      result_tag <= '0;
      exception  <= 1'b0;
    end else if (w_start) begin
      r_hi    <= '0;
      r_lo    <= w_a_mag;
      r_b_mag <= w_b_mag;
      r_neg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      r_tag   <= dest_tag_in;
      if (w_state_nxt == ST_DONE) begin
        result     <= '0;
        result_tag <= dest_tag_in;
        exception  <= 1'b1;
      end
    end else if (w_cnt_en) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
      if (w_cnt_tc) begin
        result     <= (r_state == ST_MULT) ? w_prod[WIDTH-1:0] : w_q;
        exception  <= (r_state == ST_MULT) ? w_mul_exc : w_div_exc;
        result_tag <= r_tag;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign stall       = busy || ((ctrl_mult || ctrl_div) && (r_state == ST_IDLE));
  assign result_rdy  = (r_state == ST_DONE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed plus randomized checks of multdiv_sequencer against an arithmetic reference model.
module tb_multdiv_sequencer;
  localparam int EW = 46;  // {latency[7:0], exception, tag[4:0], result[31:0]}

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_mult = 1'b0, ctrl_div = 1'b0;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic [4:0]  dest_tag_in = '0;
  logic        busy, stall, result_rdy, exception;
  logic [31:0] result;
  logic [4:0]  result_tag;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
    .operand_a(operand_a), .operand_b(operand_b), .dest_tag_in(dest_tag_in),
    .busy(busy), .stall(stall), .result(result), .result_tag(result_tag),
    .result_rdy(result_rdy), .exception(exception), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: exact signed arithmetic in 64 bits.
  function automatic logic [EW-1:0] model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] tag);
    longint sa, sb, p, q;
    logic [31:0] r;
    logic e;
    logic [7:0] lat;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'($signed(r)));
      lat = 8'd33;
    end else if (b == 32'd0) begin
      r = '0;
      e = 1'b1;
      lat = 8'd1;
    end else begin
      q = sa / sb;
      r = q[31:0];
      e = (q > 64'sd2147483647);
      lat = 8'd33;
    end
    return {lat, e, tag, r};
  endfunction

  // Driver: present a start for one cycle, then scramble the operand bus.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(posedge clock); #1;
    ctrl_mult = m; ctrl_div = d; operand_a = a; operand_b = b; dest_tag_in = tag;
    if (m || d) exp_q.push_back(model(m, a, b, tag));
    @(negedge clock);
    check("stall_start_cycle", 64'(stall), 64'd1);
    check("busy_start_cycle", 64'(busy), 64'd0);
    @(posedge clock); #1;
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
    operand_a = $urandom; operand_b = $urandom; dest_tag_in = 5'($urandom);
  endtask

  // Wait for completion; optionally pulse ctrl_div (divide by zero) mid-flight at cycle inj.
  task automatic wait_done(input string tag, input int inj);
    int lat;
    logic [EW-1:0] e;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (n == inj) begin ctrl_div = 1'b1; operand_b = '0; end
      else if (n == inj + 1) ctrl_div = 1'b0;
      if (result_rdy) begin lat = n; break; end
    end
    check({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(e[45:38]));
    check({tag, "_result"}, 64'(result), 64'(e[31:0]));
    check({tag, "_tag"}, 64'(result_tag), 64'(e[36:32]));
    check({tag, "_exception"}, 64'(exception), 64'(e[37]));
    @(negedge clock);
    check({tag, "_rdy_pulse"}, 64'(result_rdy), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_result_hold"}, 64'(result), 64'(e[31:0]));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic m, d;
    logic [31:0] a, b;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_rdy", 64'(result_rdy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_tag", 64'(result_tag), 64'd0);
    check("rst_exc", 64'(exception), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    reset = 1'b1;

    issue(1'b1, 1'b0, 32'd7, -32'd3, 5'd9);                 wait_done("mul_7x-3", 0);
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd3);  wait_done("mul_ovf", 0);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);  wait_done("mul_min_x-1", 0);
    issue(1'b0, 1'b1, -32'd100, 32'd7, 5'd17);              wait_done("div_-100/7", 0);
    issue(1'b0, 1'b1, 32'd5, 32'd0, 5'd22);                 wait_done("div_by_zero", 0);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31); wait_done("div_min/-1", 0);
    issue(1'b1, 1'b0, 32'd123, -32'd456, 5'd6);             wait_done("mul_ignore_div", 10);
    issue(1'b1, 1'b1, -32'd9, 32'd11, 5'd12);               wait_done("both_ctrl", 0);

    // Reset during a divide
    issue(1'b0, 1'b1, 32'd1000, 32'd3, 5'd8);
    repeat (15) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_rdy", 64'(result_rdy), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_exc", 64'(exception), 64'd0);
    check("midrst_tag", 64'(result_tag), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    issue(1'b1, 1'b0, -32'd25, -32'd40, 5'd19);             wait_done("mul_after_rst", 0);

    for (int i = 0; i < 14; i++) begin
      m = 1'($urandom_range(0, 1));
      d = m ? 1'($urandom_range(0, 1)) : 1'b1;
      a = pick();
      b = pick();
      issue(m, d, a, b, 5'($urandom));
      wait_done("random", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
